// File: rtl/mult_div_pkg.sv
// Shared definitions for the sequential multiplier/divider:
// operation and state encodings, plus operand helper functions.
package mult_div_pkg;

  // Widest operand the helpers handle; callers sign-extend to this and truncate back.
  localparam int unsigned MD_MAXW = 64;

  typedef enum logic [2:0] {
    MD_MULU = 3'd0,
    MD_MULS = 3'd1,
    MD_DIVU = 3'd2,
    MD_DIVS = 3'd3,
    MD_MODU = 3'd4,
    MD_MODS = 3'd5
  } md_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MULT = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_e;

  // Magnitude of a sign-extended value when signed_en, otherwise the value itself.
  function automatic logic [MD_MAXW-1:0] md_abs(input logic [MD_MAXW-1:0] value,
                                                input logic               signed_en);
    return (signed_en && value[MD_MAXW-1]) ? (~value + MD_MAXW'(1)) : value;
  endfunction

  function automatic logic md_is_mul(input logic [2:0] op);
    return (op == 3'(MD_MULU)) || (op == 3'(MD_MULS));
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == 3'(MD_DIVU)) || (op == 3'(MD_DIVS)) ||
           (op == 3'(MD_MODU)) || (op == 3'(MD_MODS));
  endfunction

  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == 3'(MD_MULS)) || (op == 3'(MD_DIVS)) || (op == 3'(MD_MODS));
  endfunction

endpackage

// File: rtl/mult_div_step.sv
// One restoring-division iteration (combinational).
// Ports:
//   r        partial remainder (always < bb on entry)
//   bb       divisor magnitude
//   nbit     next dividend bit shifted into the remainder
//   r_next_c updated partial remainder
//   q_bit_c  quotient bit produced by this step
module mult_div_step #(
  parameter int unsigned WID = 32
) (
  input  logic [WID-1:0] r,
  input  logic [WID-1:0] bb,
  input  logic           nbit,
  output logic [WID-1:0] r_next_c,
  output logic           q_bit_c
);

  logic [WID:0]   shifted;
  logic [WID+1:0] diff;

  // Extra top bit of the difference is the borrow; no borrow means bb fits.
  always_comb begin
    shifted  = {r, nbit};
    diff     = {1'b0, shifted} - {2'b00, bb};
    q_bit_c  = ~diff[WID+1];
    r_next_c = q_bit_c ? diff[WID-1:0] : shifted[WID-1:0];
  end

endmodule

// File: rtl/mult_div_w.sv
// Sequential multiplier/divider for the execute stage: unsigned/signed
// multiply, divide and modulo, one bit per cycle with fixed latency.
// Optional build macro MULDIV_FAST_MUL_EN makes multiply a single-cycle
// inferred multiplier; divide is unaffected.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   ld         start request, sampled only while idle
//   op         0 MULU 1 MULS 2 DIVU 3 DIVS 4 MODU 5 MODS (6/7 reserved)
//   a, b       operands
//   p          product (mul ops only)
//   q, r       quotient / remainder (div/mod ops only)
//   busy       operation in progress
//   done       one-cycle pulse, results valid
//   dvz, ovf   divide-by-zero / signed overflow of last div/mod
module mult_div_w
  import mult_div_pkg::*;
#(
  parameter int unsigned WID = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [2:0]       op,
  input  logic [WID-1:0]   a,
  input  logic [WID-1:0]   b,
  output logic [2*WID-1:0] p,
  output logic [WID-1:0]   q,
  output logic [WID-1:0]   r,
  output logic             busy,
  output logic             done,
  output logic             dvz,
  output logic             ovf
);

  localparam int unsigned CNTW = $clog2(WID + 1);
  localparam int unsigned PW   = 2 * WID;
  localparam logic [WID-1:0] MIN_V = {1'b1, {(WID-1){1'b0}}};

  md_state_e state, state_n;

  logic [PW-1:0]   p_n, acc, acc_n;
  logic [WID-1:0]  q_n, r_n, aa, aa_n, bb, bb_n, wq, wq_n, wr, wr_n;
  logic [CNTW-1:0] cnt, cnt_n;
  logic            busy_n, done_n, dvz_n, ovf_n;
  logic            res_sgn, res_sgn_n, rem_sgn, rem_sgn_n;
  logic            mul_op, mul_op_n, dz, dz_n, ovf_pend, ovf_pend_n;
  logic            sgn_c;
  logic [WID-1:0]  abs_a_c, abs_b_c;
  logic [WID-1:0]  step_r;
  logic            step_q;
`ifndef MULDIV_FAST_MUL_EN
  logic [WID:0]    mul_sum_c;
`endif

  mult_div_step #(.WID(WID)) u_step (
    .r        (wr),
    .bb       (bb),
    .nbit     (wq[WID-1]),
    .r_next_c (step_r),
    .q_bit_c  (step_q)
  );

  // Operand magnitudes for the latch in IDLE.
  always_comb begin
    sgn_c   = md_is_signed(op);
    abs_a_c = WID'(md_abs(MD_MAXW'($signed(a)), sgn_c));
    abs_b_c = WID'(md_abs(MD_MAXW'($signed(b)), sgn_c));
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      p        <= '0;
      q        <= '0;
      r        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dvz      <= 1'b0;
      ovf      <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      aa       <= '0;
      bb       <= '0;
      wq       <= '0;
      wr       <= '0;
      res_sgn  <= 1'b0;
      rem_sgn  <= 1'b0;
      mul_op   <= 1'b0;
      dz       <= 1'b0;
      ovf_pend <= 1'b0;
    end else begin
      state    <= state_n;
      p        <= p_n;
      q        <= q_n;
      r        <= r_n;
      busy     <= busy_n;
      done     <= done_n;
      dvz      <= dvz_n;
      ovf      <= ovf_n;
      cnt      <= cnt_n;
      acc      <= acc_n;
      aa       <= aa_n;
      bb       <= bb_n;
      wq       <= wq_n;
      wr       <= wr_n;
      res_sgn  <= res_sgn_n;
      rem_sgn  <= rem_sgn_n;
      mul_op   <= mul_op_n;
      dz       <= dz_n;
      ovf_pend <= ovf_pend_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (ld) begin
          if (md_is_mul(op))      state_n = ST_MULT;
          else if (md_is_div(op)) state_n = (b == '0) ? ST_FIX : ST_DIV;
          else                    state_n = ST_DONE;
        end
      end
`ifdef MULDIV_FAST_MUL_EN
      ST_MULT: state_n = ST_FIX;
`else
      ST_MULT: if (cnt == CNTW'(1)) state_n = ST_FIX;
`endif
      ST_DIV:  if (cnt == CNTW'(1)) state_n = ST_FIX;
      ST_FIX:  state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    p_n        = p;
    q_n        = q;
    r_n        = r;
    dvz_n      = dvz;
    ovf_n      = ovf;
    cnt_n      = cnt;
    acc_n      = acc;
    aa_n       = aa;
    bb_n       = bb;
    wq_n       = wq;
    wr_n       = wr;
    res_sgn_n  = res_sgn;
    rem_sgn_n  = rem_sgn;
    mul_op_n   = mul_op;
    dz_n       = dz;
    ovf_pend_n = ovf_pend;
    busy_n     = (state_n == ST_MULT) || (state_n == ST_DIV) || (state_n == ST_FIX);
    done_n     = (state_n == ST_DONE);
`ifndef MULDIV_FAST_MUL_EN
    mul_sum_c  = {1'b0, acc[PW-1:WID]} + (acc[0] ? {1'b0, aa} : '0);
`endif

    case (state)
      ST_IDLE: begin
        if (ld && (md_is_mul(op) || md_is_div(op))) begin
          aa_n       = abs_a_c;
          bb_n       = abs_b_c;
          res_sgn_n  = sgn_c & (a[WID-1] ^ b[WID-1]);
          rem_sgn_n  = sgn_c & a[WID-1];
          cnt_n      = CNTW'(WID);
          dvz_n      = 1'b0;
          ovf_n      = 1'b0;
          mul_op_n   = md_is_mul(op);
          dz_n       = 1'b0;
          ovf_pend_n = 1'b0;
          if (md_is_mul(op)) begin
            // Multiplier sits in the low half and is consumed from bit 0.
            acc_n = {{WID{1'b0}}, abs_b_c};
          end else if (b == '0) begin
            // Divide by zero bypasses iteration; FIX publishes these raw.
            dvz_n = 1'b1;
            dz_n  = 1'b1;
            wq_n  = '1;
            wr_n  = a;
          end else begin
            wq_n       = abs_a_c;
            wr_n       = '0;
            ovf_pend_n = sgn_c && (a == MIN_V) && (b == '1);
          end
        end
      end
      ST_MULT: begin
`ifdef MULDIV_FAST_MUL_EN
        acc_n = PW'(aa) * PW'(bb);
`else
        acc_n = {mul_sum_c, acc[WID-1:1]};
        cnt_n = cnt - CNTW'(1);
`endif
      end
      ST_DIV: begin
        // wq holds the remaining dividend bits and collects quotient bits.
        wr_n  = step_r;
        wq_n  = {wq[WID-2:0], step_q};
        cnt_n = cnt - CNTW'(1);
      end
      ST_FIX: begin
        if (mul_op) begin
          p_n = res_sgn ? (~acc + PW'(1)) : acc;
        end else if (dz) begin
          q_n = wq;
          r_n = wr;
        end else if (ovf_pend) begin
          q_n   = MIN_V;
          r_n   = '0;
          ovf_n = 1'b1;
        end else begin
          q_n = res_sgn ? (~wq + WID'(1)) : wq;
          r_n = rem_sgn ? (~wr + WID'(1)) : wr;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_div_w.sv
// Self-checking bench for mult_div_w: directed cases, randomized ops against
// an arithmetic reference model, handshake/latency and reset behaviour.
module tb_mult_div_w;

  localparam int unsigned WID = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 3;
`else
  localparam int MUL_LAT = WID + 2;
`endif
  localparam logic [WID-1:0] MINV = 32'h8000_0000;

  logic             clk = 1'b0;
  logic             rst, ld;
  logic [2:0]       op;
  logic [WID-1:0]   a, b;
  logic [2*WID-1:0] p;
  logic [WID-1:0]   q, r;
  logic             busy, done, dvz, ovf;

  int checks = 0;
  int errors = 0;

  // Reference-model state: results persist until overwritten by their owner op.
  logic [63:0] ep;
  logic [31:0] eq, er;
  logic        edvz, eovf;

  always #5 clk = ~clk;

  mult_div_w #(.WID(WID)) dut (
    .clk(clk), .rst(rst), .ld(ld), .op(op), .a(a), .b(b),
    .p(p), .q(q), .r(r), .busy(busy), .done(done), .dvz(dvz), .ovf(ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Plain arithmetic reference; returns the expected done cycle.
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat);
    int sx, sy;
    lat = 1;
    case (o)
      3'd0: begin
        ep = {32'b0, x} * {32'b0, y};
        edvz = 1'b0; eovf = 1'b0; lat = MUL_LAT;
      end
      3'd1: begin
        ep = 64'(longint'($signed(x)) * longint'($signed(y)));
        edvz = 1'b0; eovf = 1'b0; lat = MUL_LAT;
      end
      3'd2, 3'd4: begin
        eovf = 1'b0;
        edvz = (y == 0);
        if (y == 0) begin eq = '1; er = x; lat = 2; end
        else begin eq = x / y; er = x % y; lat = WID + 2; end
      end
      3'd3, 3'd5: begin
        eovf = 1'b0;
        edvz = (y == 0);
        if (y == 0) begin eq = '1; er = x; lat = 2; end
        else if (x == MINV && y == '1) begin
          eq = MINV; er = 0; eovf = 1'b1; lat = WID + 2;
        end else begin
          sx = $signed(x); sy = $signed(y);
          eq = 32'(sx / sy); er = 32'(sx % sy); lat = WID + 2;
        end
      end
      default: lat = 1;
    endcase
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int lat, got;
    model(o, x, y, lat);
    @(negedge clk);
    op = o; a = x; b = y; ld = 1'b1;
    @(posedge clk);
    #1 ld = 1'b0;
    got = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1 && lat > 1) chk("busy_c1", busy, 1'b1);
      if (done) begin got = n; break; end
    end
    chk($sformatf("latency op%0d", o), 64'(got), 64'(lat));
    chk("busy_at_done", busy, 1'b0);
    chk($sformatf("p op%0d a=%0h b=%0h", o, x, y), p, ep);
    chk($sformatf("q op%0d a=%0h b=%0h", o, x, y), 64'(q), 64'(eq));
    chk($sformatf("r op%0d a=%0h b=%0h", o, x, y), 64'(r), 64'(er));
    if (o < 3'd6) begin
      chk("dvz", dvz, edvz);
      chk("ovf", ovf, eovf);
    end
    @(negedge clk);
    chk("done_pulse_width", done, 1'b0);
  endtask

  initial begin
    int nd, lat;
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    int sel;

    ep = '0; eq = '0; er = '0; edvz = 1'b0; eovf = 1'b0;
    rst = 1'b1; ld = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_p", p, 64'd0);
    chk("rst_q", 64'(q), 64'd0);
    chk("rst_r", 64'(r), 64'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dvz", dvz, 1'b0);
    chk("rst_ovf", ovf, 1'b0);

    // Directed cases with literal expectations.
    run(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("mulu_max_lit", p, 64'hFFFF_FFFE_0000_0001);
    run(3'd1, 32'hFFFF_FFFD, 32'd7);
    chk("muls_lit", p, 64'hFFFF_FFFF_FFFF_FFEB);
    run(3'd2, 32'h1234_5678, 32'd10);
    chk("divu_q_lit", 64'(q), 64'h01D2_08A5);
    chk("divu_r_lit", 64'(r), 64'd6);
    run(3'd3, 32'hFFFF_FFF9, 32'd2);
    chk("divs_q_lit", 64'(q), 64'hFFFF_FFFD);
    chk("divs_r_lit", 64'(r), 64'hFFFF_FFFF);
    run(3'd5, 32'd7, 32'hFFFF_FFFE);
    chk("mods_q_lit", 64'(q), 64'hFFFF_FFFD);
    chk("mods_r_lit", 64'(r), 64'd1);
    run(3'd2, 32'd5, 32'd0);
    chk("dvz_lit", dvz, 1'b1);
    run(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("ovf_lit", ovf, 1'b1);
    run(3'd6, 32'd9, 32'd3);
    run(3'd7, 32'd1, 32'd1);

    // ld while busy must be ignored.
    model(3'd2, 32'd1000, 32'd7, lat);
    @(negedge clk);
    op = 3'd2; a = 32'd1000; b = 32'd7; ld = 1'b1;
    @(posedge clk);
    #1 ld = 1'b0;
    repeat (4) @(negedge clk);
    op = 3'd0; a = '1; b = '1; ld = 1'b1;
    @(posedge clk);
    #1 ld = 1'b0;
    nd = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("busy_ld_done_count", 64'(nd), 64'd1);
    chk("busy_ld_p", p, ep);
    chk("busy_ld_q", 64'(q), 64'(eq));
    chk("busy_ld_r", 64'(r), 64'(er));

    // Reset mid-divide aborts without a done pulse.
    @(negedge clk);
    op = 3'd2; a = 32'hDEAD_BEEF; b = 32'd3; ld = 1'b1;
    @(posedge clk);
    #1 ld = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    ep = '0; eq = '0; er = '0; edvz = 1'b0; eovf = 1'b0;
    @(negedge clk);
    chk("midrst_p", p, 64'd0);
    chk("midrst_q", 64'(q), 64'd0);
    chk("midrst_r", 64'(r), 64'd0);
    chk("midrst_busy", busy, 1'b0);
    nd = 0;
    repeat (50) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("midrst_no_done", 64'(nd), 64'd0);
    run(3'd2, 32'hDEAD_BEEF, 32'd3);

    // Randomized ops, with biased corner operands.
    for (int i = 0; i < 40; i++) begin
      ro  = 3'($urandom_range(0, 5));
      rx  = $urandom;
      ry  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) ry = '0;
      if (sel == 1) ry = 32'($urandom_range(1, 15));
      if (sel == 2) begin rx = MINV; ry = '1; end
      if (sel == 3) rx = 32'($urandom_range(0, 100));
      run(ro, rx, ry);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
